// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers returned words with their PCs, flushes on redirect.
// Optional FETCH_PERF_CNT_EN adds pop and redirect performance counters.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   rsp_pc_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] drop_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW:0]   in_use;
    logic [CW-1:0] drop_next;
    logic [31:0]   redirect_aligned;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign in_use         = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid = rst_n && (state_reg == RUN) && !redirect_valid
                            && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    assign fifo_empty = (count_reg == '0);
    assign out_valid  = !fifo_empty && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign push       = imem_rsp_valid && !redirect_valid && (drop_reg == '0);
    assign out_pc     = fifo_empty ? 32'd0 : mem_pc[rd_ptr_reg];
    assign out_instr  = fifo_empty ? 32'd0 : mem_instr[rd_ptr_reg];

    assign drop_next        = outstanding_reg - CW'(imem_rsp_valid);
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Responses are in order, so the next kept word belongs to the redirect target.
                fetch_pc_reg <= redirect_aligned;
                rsp_pc_reg   <= redirect_aligned;
                count_reg    <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                drop_reg     <= drop_next;
                state_reg    <= (drop_next != '0) ? FLUSH : RUN;
            end else begin
                if (accept)
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    rsp_pc_reg <= rsp_pc_reg + 32'd4;
                end
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if (imem_rsp_valid && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CW'(1);
                    if (drop_reg == CW'(1))
                        state_reg <= RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_reg]    <= rsp_pc_reg;
            mem_instr[wr_ptr_reg] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
            perf_flush_cnt <= perf_flush_cnt + 32'(redirect_valid);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model returns ~addr, scoreboard checks every consumed {pc, instr}.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    instr_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int redirects = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Memory model: in-order, fixed latency per request, contents are ~addr.
    typedef struct {logic [31:0] addr; int due;} req_t;
    req_t pend[$];
    int   cyc = 0;
    int   lat = 1;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat - 1});
        end
    end

    always @(negedge clk) begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pend[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard of expected consumed entries.
    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
    exp_t exp_q[$];

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = ~e.pc;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got out_pc %h, expected no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
            end
        end
    end

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (out_valid) seen = 1'b1;
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        chk({name, "_pc"}, out_pc, exp_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        expect_seq(32'h0040_0000, 64);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0040_0000);

        // Streaming: ready memory, 1-cycle latency, CPU always ready
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        wait_valid("t1_first", 32'h0040_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("t1_consec_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure: FIFO fills to DEPTH and fetching stops
        @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("t2_count", 32'(dut.count_reg), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_in_flight", 32'(pend.size()), 32'd0);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Redirect with two requests in flight at latency 3
        imem_req_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (pend.size() == 0 && !out_valid) found = 1'b1;
        end
        chk("t3_idle", 32'(found), 32'd1);
        @(negedge clk);
        lat = 3;
        imem_req_ready = 1'b1;
        #2;
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        redirects++;
        expect_seq(32'h0040_0100, 64);
        #2;
        chk("t3_outstanding", 32'(pend.size()), 32'd2);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("t3_flush_a", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("t3_flush_b", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("t3_run_req", 32'(imem_req_valid), 32'd1);
        chk("t3_run_addr", imem_req_addr, 32'h0040_0100);
        @(negedge clk);
        lat = 1;
        imem_req_ready = 1'b1;
        wait_valid("t3_next", 32'h0040_0100);
        repeat (6) @(negedge clk);

        // Redirect coinciding with a response and out_ready; misaligned target
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0203;
        redirects++;
        expect_seq(32'h0040_0200, 64);
        #2;
        chk("t4_rsp_same_cycle", 32'(imem_rsp_valid), 32'd1);
        chk("t4_out_valid_low", 32'(out_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("t4_fifo_empty", 32'(out_valid), 32'd0);
        chk("t4_req_addr", imem_req_addr, 32'h0040_0200);
        wait_valid("t4_next", 32'h0040_0200);
        repeat (4) @(negedge clk);

        // Fetch address wraps past 0xFFFFFFFC
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        redirects++;
        expect_seq(32'hFFFF_FFF8, 64);
        @(negedge clk);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #2;
            if (imem_req_valid && imem_req_addr == 32'hFFFF_FFFC) found = 1'b1;
            else @(negedge clk);
        end
        chk("t5_reach_top", 32'(found), 32'd1);
        @(negedge clk);
        #2;
        chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
        repeat (6) @(negedge clk);

        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("pops_enough", 32'(pops >= 20), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(pops));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(redirects));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
